uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_sync2.sv | 28 ++
 rtl/uart_rx.sv | 158 +++++++++++++++
 tb/tb_uart_rx.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receiver and transmitter.
//   uart_state_t : receiver/transmitter frame states
//   OVERSAMPLE   : clk cycles per bit = prescale * OVERSAMPLE
//   CNT_W, cnt_t : width and type of the bit-timing down-counter
`timescale 1ns/1ps
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP,
      ST_WAIT_HIGH
   } uart_state_t;

   localparam int OVERSAMPLE = 8;
   localparam int CNT_W      = 19;

   typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/uart_sync2.sv
// uart_sync2: two-flop synchronizer for an asynchronous input.
//   clk   : sampling clock
//   rst_n : synchronous active-low reset, both flops load RST_VAL
//   d     : asynchronous input
//   q     : synchronized output (two cycles of latency)
`timescale 1ns/1ps
module uart_sync2 #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1-style serial receiver (DATA_WIDTH data bits, LSB first,
// no parity, one stop bit) with an AXI-stream style output register.
//   clk, rst_n      : clock, synchronous active-low reset
//   rxd             : asynchronous serial line, idle high
//   prescale        : bit period = prescale*8 clk cycles (0 acts as 1)
//   m_axis_tdata    : received word
//   m_axis_tvalid   : tdata holds an unconsumed word
//   m_axis_tready   : downstream accepts the word
//   busy            : frame in progress (START/DATA/STOP)
//   overrun_error   : one-cycle pulse, unconsumed word overwritten
//   frame_error     : one-cycle pulse, stop bit sampled low
// Build option: define UART_RX_MAJORITY_EN to take each bit as the
// 2-of-3 majority of the last three synchronized samples ending at the
// sample point. Timing is the same with or without it.
//
// state        | meaning
// ST_IDLE      | line idle, waiting for a falling edge
// ST_START     | timing to mid start bit, confirming it is still low
// ST_DATA      | sampling data bits at bit centres
// ST_STOP      | sampling the stop bit
// ST_WAIT_HIGH | stop bit was low; hold off until the line returns high
`timescale 1ns/1ps
module uart_rx
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   input  logic                  rxd,
   output logic                  busy,
   output logic                  overrun_error,
   output logic                  frame_error,
   input  logic [15:0]           prescale
);

   localparam int             BW       = $clog2(DATA_WIDTH + 1);
   localparam logic [BW-1:0]  LAST_BIT = BW'(DATA_WIDTH - 1);

   uart_state_t           state;
   cnt_t                  cnt;
   logic [15:0]           p;
   logic [15:0]           p_eff;
   logic [DATA_WIDTH-1:0] shreg;
   logic [BW-1:0]         bit_idx;
   logic                  rxd_s;
   logic                  bit_s;
   logic                  sample;
   logic [1:0]            settle;
   logic                  armed;

   uart_sync2 #(.RST_VAL(1'b1)) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (rxd),
      .q     (rxd_s)
   );

   assign p_eff  = (prescale == 16'd0) ? 16'd1 : prescale;
   assign sample = (cnt == '0);

`ifdef UART_RX_MAJORITY_EN
   logic [1:0] hist;

   always_ff @(posedge clk) begin
      if (!rst_n) hist <= 2'b11;
      else        hist <= {hist[0], rxd_s};
   end

   assign bit_s = (rxd_s & hist[0]) | (rxd_s & hist[1]) | (hist[0] & hist[1]);
`else
   assign bit_s = rxd_s;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= ST_IDLE;
         cnt           <= '0;
         p             <= 16'd1;
         shreg         <= '0;
         bit_idx       <= '0;
         settle        <= 2'b00;
         armed         <= 1'b0;
         m_axis_tdata  <= '0;
         m_axis_tvalid <= 1'b0;
         busy          <= 1'b0;
         overrun_error <= 1'b0;
         frame_error   <= 1'b0;
      end else begin
         overrun_error <= 1'b0;
         frame_error   <= 1'b0;
         // The synchronizer comes out of reset reading high; only trust
         // rxd_s once it reflects the real line, so a reset in the middle
         // of a low bit cannot be mistaken for a new start edge.
         settle        <= {settle[0], 1'b1};
         armed         <= rxd_s & settle[1];

         if (m_axis_tvalid && m_axis_tready) m_axis_tvalid <= 1'b0;

         case (state)
            ST_IDLE: begin
               if (!rxd_s && armed) begin
                  p     <= p_eff;
                  cnt   <= cnt_t'(p_eff) * cnt_t'(OVERSAMPLE / 2) - cnt_t'(2);
                  busy  <= 1'b1;
                  state <= ST_START;
               end
            end
            ST_START: begin
               if (!sample) begin
                  cnt <= cnt - cnt_t'(1);
               end else if (!bit_s) begin
                  cnt     <= cnt_t'(p) * cnt_t'(OVERSAMPLE) - cnt_t'(1);
                  bit_idx <= '0;
                  state   <= ST_DATA;
               end else begin
                  busy  <= 1'b0;
                  state <= ST_IDLE;
               end
            end
            ST_DATA: begin
               if (!sample) begin
                  cnt <= cnt - cnt_t'(1);
               end else begin
                  shreg <= DATA_WIDTH'({bit_s, shreg} >> 1);
                  cnt   <= cnt_t'(p) * cnt_t'(OVERSAMPLE) - cnt_t'(1);
                  if (bit_idx == LAST_BIT) state <= ST_STOP;
                  else                     bit_idx <= bit_idx + BW'(1);
               end
            end
            ST_STOP: begin
               if (!sample) begin
                  cnt <= cnt - cnt_t'(1);
               end else begin
                  busy <= 1'b0;
                  if (bit_s) begin
                     m_axis_tdata  <= shreg;
                     m_axis_tvalid <= 1'b1;
                     overrun_error <= m_axis_tvalid && !m_axis_tready;
                     state         <= ST_IDLE;
                  end else begin
                     frame_error <= 1'b1;
                     state       <= ST_WAIT_HIGH;
                  end
               end
            end
            ST_WAIT_HIGH: begin
               if (rxd_s) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
module tb_uart_rx;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  tdata;
   logic        tvalid;
   logic        tready = 1'b1;
   logic        rxd = 1'b1;
   logic        busy;
   logic        ovr;
   logic        fe;
   logic [15:0] prescale = 16'd4;

   always #5 clk = ~clk;

   uart_rx #(.DATA_WIDTH(8)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .m_axis_tdata  (tdata),
      .m_axis_tvalid (tvalid),
      .m_axis_tready (tready),
      .rxd           (rxd),
      .busy          (busy),
      .overrun_error (ovr),
      .frame_error   (fe),
      .prescale      (prescale)
   );

   int checks = 0;
   int failures = 0;

   // monitor state, only written by the monitor process
   logic [7:0] rx_q[$];
   int ovr_cnt = 0, fe_cnt = 0, busy_cnt = 0, tv_cnt = 0;

   always @(negedge clk) begin
      if (rst_n) begin
         if (tvalid && tready) rx_q.push_back(tdata);
         if (ovr)    ovr_cnt++;
         if (fe)     fe_cnt++;
         if (busy)   busy_cnt++;
         if (tvalid) tv_cnt++;
      end
   end

   // per-cycle line waveform and side events applied by play()
   bit wave[$];
   int ev_pre_idx = -1;
   logic [15:0] ev_pre_val = 16'd0;
   int tr_on = -1, tr_off = -1, rst_idx = -1;

   int b_rx, b_ovr, b_fe, b_busy, b_tv;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic snap();
      b_rx = rx_q.size(); b_ovr = ovr_cnt; b_fe = fe_cnt;
      b_busy = busy_cnt; b_tv = tv_cnt;
   endtask

   function automatic int eff(input logic [15:0] p);
      return (p == 16'd0) ? 1 : int'(p);
   endfunction

   // start bit at the first appended index; bad stop = low for two bit times
   task automatic add_frame(input logic [15:0] p, input logic [7:0] d,
                            input bit stop_ok, input int gap);
      int bl;
      bl = 8 * eff(p);
      repeat (bl) wave.push_back(1'b0);
      for (int i = 0; i < 8; i++) repeat (bl) wave.push_back(d[i]);
      if (!stop_ok) repeat (2 * bl) wave.push_back(1'b0);
      repeat (bl + gap) wave.push_back(1'b1);
   endtask

   task automatic play();
      for (int i = 0; i < wave.size(); i++) begin
         @(posedge clk); #1;
         if (rst_idx >= 0 && i == rst_idx + 1) begin
            check("rst_tvalid", tvalid, 0);
            check("rst_tdata", tdata, 0);
            check("rst_busy", busy, 0);
            check("rst_errs", {ovr, fe}, 0);
            rst_n = 1'b1;
         end
         rxd = wave[i];
         if (i == ev_pre_idx) prescale = ev_pre_val;
         if (i == tr_on)  tready = 1'b1;
         if (i == tr_off) tready = 1'b0;
         if (i == rst_idx) rst_n = 1'b0;
      end
      wave.delete();
      ev_pre_idx = -1; tr_on = -1; tr_off = -1; rst_idx = -1;
      @(posedge clk); #1;
   endtask

   task automatic expect_byte(input string name, input logic [7:0] b);
      check({name, "_cnt"}, rx_q.size() - b_rx, 1);
      if (rx_q.size() > b_rx) check(name, rx_q[b_rx], b);
   endtask

   typedef struct {
      logic [15:0] p;
      logic [7:0]  data;
      bit          stop_ok;
   } vec_t;

   vec_t vecs[7];
   logic [7:0] exp_q[$];
   int exp_fe;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{16'd4, 8'hA5, 1'b1};
      vecs[1] = '{16'd1, 8'h00, 1'b1};
      vecs[2] = '{16'd0, 8'hFF, 1'b1};
      vecs[3] = '{16'd2, 8'h5A, 1'b1};
      vecs[4] = '{16'd4, 8'h3C, 1'b0};
      vecs[5] = '{16'd4, 8'h81, 1'b1};
      vecs[6] = '{16'd7, 8'hC3, 1'b1};

      repeat (4) @(posedge clk);
      @(negedge clk);
      check("reset_tvalid", tvalid, 0);
      check("reset_busy", busy, 0);
      check("reset_tdata", tdata, 0);
      check("reset_errs", {ovr, fe}, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (8) @(posedge clk);
      #1;

      // table of single frames, tready held high
      foreach (vecs[k]) begin
         snap();
         prescale = vecs[k].p;
         add_frame(vecs[k].p, vecs[k].data, vecs[k].stop_ok, 16);
         play();
         check($sformatf("tbl%0d_fe", k), fe_cnt - b_fe, vecs[k].stop_ok ? 0 : 1);
         check($sformatf("tbl%0d_ovr", k), ovr_cnt - b_ovr, 0);
         check($sformatf("tbl%0d_tv_cycles", k), tv_cnt - b_tv, vecs[k].stop_ok ? 1 : 0);
         if (vecs[k].stop_ok) begin
            expect_byte($sformatf("tbl%0d_data", k), vecs[k].data);
            check($sformatf("tbl%0d_busy_len", k),
                  ((busy_cnt - b_busy) >= 72 * eff(vecs[k].p)) &&
                  ((busy_cnt - b_busy) <= 80 * eff(vecs[k].p)), 1);
         end else begin
            check($sformatf("tbl%0d_nodata", k), rx_q.size() - b_rx, 0);
         end
      end

      // start-bit glitch: low 10 cycles then high
      snap();
      prescale = 16'd4;
      repeat (10) wave.push_back(1'b0);
      repeat (30) wave.push_back(1'b1);
      play();
      check("glitch_busy_len", ((busy_cnt - b_busy) >= 1) && ((busy_cnt - b_busy) <= 20), 1);
      check("glitch_busy_end", busy, 0);
      check("glitch_no_tvalid", tv_cnt - b_tv, 0);
      check("glitch_no_err", (fe_cnt - b_fe) + (ovr_cnt - b_ovr), 0);

      // prescale change mid-frame must not disturb the frame
      snap();
      prescale = 16'd4;
      add_frame(16'd4, 8'h96, 1'b1, 16);
      ev_pre_idx = 100; ev_pre_val = 16'd9;
      play();
      expect_byte("presc_change", 8'h96);
      prescale = 16'd4;

      // overrun: two frames with tready low
      snap();
      tready = 1'b0;
      add_frame(16'd4, 8'h11, 1'b1, 16);
      add_frame(16'd4, 8'h22, 1'b1, 16);
      play();
      check("ovr_pulse", ovr_cnt - b_ovr, 1);
      check("ovr_tdata", tdata, 8'h22);
      check("ovr_tvalid", tvalid, 1);
      check("ovr_no_consume", rx_q.size() - b_rx, 0);

      // tready exactly in the stop-sample cycle: consume 0x22, load 0x44
      snap();
      add_frame(16'd4, 8'h44, 1'b1, 16);
      tr_on = 76 * 4 + 1; tr_off = 76 * 4 + 2;
      play();
      check("exact_no_ovr", ovr_cnt - b_ovr, 0);
      expect_byte("exact_consumed", 8'h22);
      check("exact_tdata", tdata, 8'h44);
      check("exact_tvalid", tvalid, 1);
      snap();
      tready = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      expect_byte("exact_drain", 8'h44);
      check("exact_tvalid_fall", tvalid, 0);

      // reset during bit 3 of 0xF0, then 0x0F
      snap();
      add_frame(16'd4, 8'hF0, 1'b1, 16);
      rst_idx = 140;
      play();
      add_frame(16'd4, 8'h0F, 1'b1, 16);
      play();
      expect_byte("rst_next_byte", 8'h0F);
      check("rst_no_fe", fe_cnt - b_fe, 0);

      // single-cycle glitch at the sample point of data bit 2 of 0x55
      snap();
      add_frame(16'd4, 8'h55, 1'b1, 16);
      wave[4 * 4 - 1 + 8 * 4 * 3] = 1'b0;
      play();
`ifdef UART_RX_MAJORITY_EN
      expect_byte("maj_glitch", 8'h55);
`else
      expect_byte("maj_glitch", 8'h51);
`endif

      // randomized frames against a queue model
      snap();
      exp_q.delete();
      exp_fe = 0;
      for (int n = 0; n < 14; n++) begin
         logic [15:0] rp;
         logic [7:0]  rd;
         bit          ok;
         rp = 16'($urandom_range(1, 6));
         rd = 8'($urandom);
         ok = ($urandom_range(0, 3) != 0);
         if (ok) exp_q.push_back(rd);
         else    exp_fe++;
         prescale = rp;
         add_frame(rp, rd, ok, int'($urandom_range(2, 40)));
         play();
      end
      check("rand_count", rx_q.size() - b_rx, exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
         if (b_rx + i < rx_q.size())
            check($sformatf("rand_data%0d", i), rx_q[b_rx + i], exp_q[i]);
      end
      check("rand_fe", fe_cnt - b_fe, exp_fe);
      check("rand_ovr", ovr_cnt - b_ovr, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
